// File: rtl/ucode_loader.sv
// Framed byte-stream loader for the microcode store; holds microcode_exec in reset until an image is loaded.
// Define UCODE_LOADER_CSUM_EN to expect and verify a trailing XOR checksum byte.
module ucode_loader #(
    parameter int          DEPTH     = 129,
    parameter int          ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    input  logic              i_restart,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic              o_load_done,
    output logic              o_load_err,
    output logic              o_exec_reset
);

    localparam logic [2:0] S_SYNC  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CSUM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    logic [2:0]        r_state;
    logic [1:0]        r_byte_idx;
    logic [ADDR_W-1:0] r_word_idx;
    logic [ADDR_W-1:0] r_last_idx;
    logic [31:0]       r_word;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_load_done;
    logic              r_load_err;
    logic              r_exec_reset;
`ifdef UCODE_LOADER_CSUM_EN
    logic [7:0]        r_csum;
`endif

    logic        w_accept;
    logic        w_bad_count;
    logic [31:0] w_word_next;

    assign o_in_ready  = ((r_state == S_SYNC) || (r_state == S_COUNT) ||
                          (r_state == S_DATA) || (r_state == S_CSUM)) && !i_restart;
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_bad_count = (i_in_data == 8'd0) || ({24'd0, i_in_data} > 32'(DEPTH));
    // Little-endian assembly: each new byte enters at the top and earlier bytes slide down.
    assign w_word_next = {i_in_data, r_word[31:8]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_SYNC;
            r_byte_idx   <= 2'd0;
            r_word_idx   <= '0;
            r_last_idx   <= '0;
            r_word       <= 32'd0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= 32'd0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_exec_reset <= 1'b1;
`ifdef UCODE_LOADER_CSUM_EN
            r_csum       <= 8'd0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            if (i_restart) begin
                r_state      <= S_SYNC;
                r_byte_idx   <= 2'd0;
                r_word_idx   <= '0;
                r_load_done  <= 1'b0;
                r_load_err   <= 1'b0;
                r_exec_reset <= 1'b1;
`ifdef UCODE_LOADER_CSUM_EN
                r_csum       <= 8'd0;
`endif
            end else begin
                case (r_state)
                    S_SYNC: begin
                        if (w_accept && (i_in_data == SYNC_BYTE)) begin
                            r_state <= S_COUNT;
                        end
                    end
                    S_COUNT: begin
                        if (w_accept) begin
                            if (w_bad_count) begin
                                r_state    <= S_ERR;
                                r_load_err <= 1'b1;
                            end else begin
                                r_state    <= S_DATA;
                                r_last_idx <= ADDR_W'(i_in_data - 8'd1);
                                r_word_idx <= '0;
                                r_byte_idx <= 2'd0;
`ifdef UCODE_LOADER_CSUM_EN
                                r_csum     <= i_in_data;
`endif
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_accept) begin
                            r_word     <= w_word_next;
                            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef UCODE_LOADER_CSUM_EN
                            r_csum     <= r_csum ^ i_in_data;
`endif
                            if (r_byte_idx == 2'd3) begin
                                r_wr_en    <= 1'b1;
                                r_wr_addr  <= r_word_idx;
                                r_wr_data  <= w_word_next;
                                r_word_idx <= r_word_idx + 1'b1;
                                if (r_word_idx == r_last_idx) begin
`ifdef UCODE_LOADER_CSUM_EN
                                    r_state <= S_CSUM;
`else
                                    r_state <= S_DONE;
`endif
                                end
                            end
                        end
                    end
                    S_CSUM: begin
`ifdef UCODE_LOADER_CSUM_EN
                        if (w_accept) begin
                            if (i_in_data == r_csum) begin
                                r_state      <= S_DONE;
                                r_load_done  <= 1'b1;
                                r_exec_reset <= 1'b0;
                            end else begin
                                r_state    <= S_ERR;
                                r_load_err <= 1'b1;
                            end
                        end
`else
                        r_state <= S_ERR;
                        r_load_err <= 1'b1;
`endif
                    end
                    S_DONE: begin
                        // Without a checksum byte, done lags entry by a cycle so the last write strobe leads it.
                        r_load_done  <= 1'b1;
                        r_exec_reset <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_load_done  = r_load_done;
    assign o_load_err   = r_load_err;
    assign o_exec_reset = r_exec_reset;

endmodule

// File: tb/tb_ucode_loader.sv
// Directed self-checking bench for ucode_loader; follows UCODE_LOADER_CSUM_EN to decide whether frames carry a checksum.
module tb_ucode_loader;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_in_valid;
    logic [7:0]  i_in_data;
    logic        o_in_ready;
    logic        i_restart;
    logic        o_wr_en;
    logic [7:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_load_done;
    logic        o_load_err;
    logic        o_exec_reset;

    int checks   = 0;
    int failures = 0;

    logic [31:0] frameWords [0:255];
    logic [7:0]  logAddr [$];
    logic [31:0] logData [$];

    ucode_loader #(.DEPTH(129), .ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_in_valid   (i_in_valid),
        .i_in_data    (i_in_data),
        .o_in_ready   (o_in_ready),
        .i_restart    (i_restart),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_load_done  (o_load_done),
        .o_load_err   (o_load_err),
        .o_exec_reset (o_exec_reset)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Every strobed cycle is logged, so a strobe held two cycles shows up as an extra entry.
    always @(posedge i_clk) begin
        #2;
        if (o_wr_en === 1'b1) begin
            logAddr.push_back(o_wr_addr);
            logData.push_back(o_wr_data);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit gaps);
        int waitCycles;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                i_in_valid = 1'b0;
                i_in_data  = 8'($urandom);
                @(negedge i_clk);
            end
        end
        i_in_valid = 1'b1;
        i_in_data  = b;
        #1;
        waitCycles = 0;
        while (!o_in_ready && waitCycles < 16) begin
            @(negedge i_clk);
            #1;
            waitCycles++;
        end
        if (!o_in_ready) checkOutput("in_ready_timeout", 32'd0, 32'd1);
        else @(posedge i_clk);
        @(negedge i_clk);
        i_in_valid = 1'b0;
    endtask

    task automatic restartPulse();
        i_restart = 1'b1;
        #1;
        checkOutput("ready_in_restart", 32'(o_in_ready), 32'd0);
        @(negedge i_clk);
        i_restart = 1'b0;
        #1;
        checkOutput("restart_done", 32'(o_load_done), 32'd0);
        checkOutput("restart_err", 32'(o_load_err), 32'd0);
        checkOutput("restart_exec", 32'(o_exec_reset), 32'd1);
        logAddr.delete();
        logData.delete();
    endtask

    task automatic checkWrite(input int k);
        checkOutput("wr_en", 32'(o_wr_en), 32'd1);
        checkOutput("wr_addr", 32'(o_wr_addr), 32'(k));
        checkOutput("wr_data", o_wr_data, frameWords[k]);
        checkOutput("done_before_last_write", 32'(o_load_done), 32'd0);
    endtask

    task automatic sendFrame(input int n, input bit gaps);
        logic [7:0] csum;
        logic [7:0] b;
        csum = n[7:0];
        applyStimulus(8'hA5, gaps);
        applyStimulus(n[7:0], gaps);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
                b = frameWords[k][8*j +: 8];
                csum ^= b;
                applyStimulus(b, gaps);
            end
            checkWrite(k);
        end
`ifdef UCODE_LOADER_CSUM_EN
        applyStimulus(csum, gaps);
`endif
        @(negedge i_clk);
        checkOutput("frame_done", 32'(o_load_done), 32'd1);
        checkOutput("frame_exec", 32'(o_exec_reset), 32'd0);
        checkOutput("frame_err", 32'(o_load_err), 32'd0);
        checkOutput("frame_ready", 32'(o_in_ready), 32'd0);
        checkOutput("frame_writes", 32'(logAddr.size()), 32'(n));
    endtask

    task automatic checkBadCount(input logic [7:0] n);
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(n, 1'b0);
        checkOutput("badn_err", 32'(o_load_err), 32'd1);
        checkOutput("badn_exec", 32'(o_exec_reset), 32'd1);
        checkOutput("badn_ready", 32'(o_in_ready), 32'd0);
        checkOutput("badn_done", 32'(o_load_done), 32'd0);
        @(negedge i_clk);
        checkOutput("badn_no_writes", 32'(logAddr.size()), 32'd0);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_wr_en", 32'(o_wr_en), 32'd0);
        checkOutput("rst_wr_addr", 32'(o_wr_addr), 32'd0);
        checkOutput("rst_wr_data", o_wr_data, 32'd0);
        checkOutput("rst_done", 32'(o_load_done), 32'd0);
        checkOutput("rst_err", 32'(o_load_err), 32'd0);
        checkOutput("rst_exec", 32'(o_exec_reset), 32'd1);
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_in_valid = 1'b0;
        i_in_data  = 8'h00;
        i_restart  = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        checkResetValues();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        checkOutput("ready_after_reset", 32'(o_in_ready), 32'd1);
        @(negedge i_clk);

        // Two-word image
        frameWords[0] = 32'h12345678;
        frameWords[1] = 32'hDEADBEEF;
        sendFrame(2, 1'b0);
        checkOutput("t1_addr0", 32'(logAddr[0]), 32'd0);
        checkOutput("t1_data1", logData[1], 32'hDEADBEEF);
        restartPulse();

        // Leading garbage is skipped while hunting for sync
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        checkOutput("t2_no_writes", 32'(logAddr.size()), 32'd0);
        frameWords[0] = 32'h01020304;
        sendFrame(1, 1'b0);
        restartPulse();

        // Single word, then a wrong checksum when one is expected
        frameWords[0] = 32'hDDCCBBAA;
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'hBB, 1'b0);
        applyStimulus(8'hCC, 1'b0);
        applyStimulus(8'hDD, 1'b0);
        checkWrite(0);
`ifdef UCODE_LOADER_CSUM_EN
        applyStimulus(8'h00, 1'b0);
        checkOutput("t3_err", 32'(o_load_err), 32'd1);
        checkOutput("t3_exec", 32'(o_exec_reset), 32'd1);
        checkOutput("t3_done", 32'(o_load_done), 32'd0);
`else
        @(negedge i_clk);
        checkOutput("t3_done", 32'(o_load_done), 32'd1);
        checkOutput("t3_exec", 32'(o_exec_reset), 32'd0);
`endif
        checkOutput("t3_ready", 32'(o_in_ready), 32'd0);
        checkOutput("t3_writes", 32'(logAddr.size()), 32'd1);
        restartPulse();

        // Zero count and count above DEPTH
        checkBadCount(8'h00);
        restartPulse();
        checkBadCount(8'h82);
        restartPulse();

        // Largest legal image fills every index
        for (int i = 0; i < 129; i++) frameWords[i] = 32'hC0DE0000 | 32'(i);
        sendFrame(129, 1'b0);
        checkOutput("full_last_addr", 32'(logAddr[128]), 32'd128);
        checkOutput("full_last_data", logData[128], 32'hC0DE0080);
        restartPulse();

        // Gappy valid must not disturb write timing relative to accepted bytes
        frameWords[0] = 32'h11223344;
        frameWords[1] = 32'h55667788;
        frameWords[2] = 32'h99AABBCC;
        sendFrame(3, 1'b1);
        restartPulse();

        // Abort mid word 1, then a fresh single-word image
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(8'h02, 1'b0);
        for (int j = 0; j < 6; j++) applyStimulus(8'(8'h30 + j), 1'b0);
        restartPulse();
        frameWords[0] = 32'hCAFEF00D;
        sendFrame(1, 1'b0);
        checkOutput("abort_addr", 32'(logAddr[0]), 32'd0);
        checkOutput("abort_data", logData[0], 32'hCAFEF00D);
        restartPulse();

        // Asynchronous reset in the middle of a frame
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(8'h03, 1'b0);
        for (int j = 0; j < 6; j++) applyStimulus(8'(8'h40 + j), 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkResetValues();
        checkOutput("rst_ready", 32'(o_in_ready), 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        logAddr.delete();
        logData.delete();
        @(negedge i_clk);
        frameWords[0] = 32'h0BADF00D;
        frameWords[1] = 32'hFEEDFACE;
        frameWords[2] = 32'h76543210;
        sendFrame(3, 1'b0);
        checkOutput("post_rst_data2", logData[2], 32'h76543210);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule

// File: doc/ucode_loader.md
Name: ucode_loader

Overview:
- Write-side counterpart to microcode_exec.
- Receives a framed byte stream over a valid/ready link, assembles 32-bit uops and writes them into the microcode store that microcode_exec reads.
- Holds the executor in reset until a complete, checksum-clean image has been loaded, then releases it.
- Sits between the debug/boot byte channel and the uop RAM.

Parameters:
- DEPTH, 129: number of uop words in the store (indices 0..DEPTH-1).
- ADDR_W, 8: width of wr_addr; must satisfy 2**ADDR_W >= DEPTH.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- restart  input  1  single-cycle pulse: abort or clear, then re-arm for a new frame.
- wr_en  output  1  one-cycle write strobe to the uop store.
- wr_addr  output  ADDR_W  uop index being written.
- wr_data  output  32  assembled uop.
- load_done  output  1  image loaded and verified; level-held.
- load_err  output  1  frame rejected; level-held.
- exec_reset  output  1  reset to microcode_exec; 1 holds the executor in reset.

Behaviour:
- Reset (reset=0, async) values:
  - state=S_SYNC.
  - wr_en=0, wr_addr=0, wr_data=0.
  - load_done=0, load_err=0, exec_reset=1.
  - Byte index, word count and checksum cleared.
- Reset does not touch store contents; a partial word in flight is discarded.
- Handshake:
  - A byte is accepted on a rising edge where in_valid && in_ready.
  - in_ready = (state in S_SYNC/S_COUNT/S_DATA/S_CSUM) && !restart.
  - in_data may change freely when not accepted.
- Frame format: SYNC_BYTE, then N (1 byte), then N words of 4 bytes each (little-endian, byte 0 = bits 7:0), then checksum byte.
- Checksum: XOR of the N byte and all payload bytes.
- S_SYNC:
  - Accepted byte == SYNC_BYTE -> S_COUNT.
  - Any other byte is discarded; stay in S_SYNC.
- S_COUNT:
  - N==0 or N>DEPTH -> S_ERR.
  - Otherwise latch N, seed csum=N, word index=0 -> S_DATA.
- S_DATA:
  - Shift each accepted byte into the word register; csum ^= byte.
  - On the 4th byte of word k, the following cycle has wr_en=1, wr_addr=k, wr_data=word, for exactly one cycle.
  - After word N-1 -> S_CSUM.
  - No stall: writes never back-pressure the stream.
- S_CSUM:
  - Accepted byte == csum -> S_DONE.
  - Otherwise -> S_ERR.
- S_DONE:
  - load_done=1 and exec_reset=0 from the cycle after the checksum byte is accepted.
  - in_ready=0.
- S_ERR:
  - load_err=1 from the cycle after the offending byte is accepted.
  - exec_reset stays 1; in_ready=0.
- restart:
  - From any state, at the next edge: -> S_SYNC, load_done=0, load_err=0, exec_reset=1.
  - Any partial word is dropped; in_ready is low during the restart cycle.
- Simultaneous final write and done: the write strobe for the last word always precedes load_done by at least one cycle.
- Counters: word index is ADDR_W bits; byte index is 2 bits and wraps 3->0 at each word boundary.

Optional Feature:
- Macro: UCODE_LOADER_CSUM_EN.
- Defined: checksum byte expected and checked as above.
- Undefined:
  - No checksum byte in the frame and no csum logic.
  - After word N-1 the FSM goes directly to S_DONE.
  - load_err is raised only for a bad N.

Test Plan:
- Reset then frame A5,02, 78,56,34,12, EF,BE,AD,DE, csum=02^78^56^34^12^EF^BE^AD^DE -> writes (0,0x12345678), (1,0xDEADBEEF); load_done=1, exec_reset=0, load_err=0.
- Bytes 00,FF,A5,01,04,03,02,01,csum -> leading 00,FF ignored; single write (0,0x01020304); done.
- Frame A5,01,AA,BB,CC,DD, wrong csum 00 -> one write to addr 0 occurs, then load_err=1, exec_reset stays 1, in_ready=0.
- A5,00 and A5,0x82 (130 > DEPTH) -> load_err=1 with no wr_en pulses.
- Toggle in_valid randomly during a 3-word frame -> identical writes and timing relative to accepted bytes; restart pulse mid-word-1 then a fresh 1-word frame -> only the new word is written, done asserts.
- Assert reset low mid-frame (after 6 payload bytes) -> outputs at reset values immediately; after release a full frame loads correctly.
